// File: rtl/cmd_clk_phase_delay_line.sv
// Glitch-free phase / fine-delay stage for the CDR command clock: an FSM sequences every tap or phase change.
// Optional switch counter enabled by defining CMD_CLK_SWITCH_CNT_EN (otherwise SwitchCnt is tied to zero).
module cmd_clk_phase_delay_line #(
  parameter int NTAPS      = 16,
  parameter int SEL_W      = 4,
  parameter int TIMEOUT    = 255,
  parameter int SETTLE_CYC = 4,
  parameter int TMR_W      = 8
) (
  input  logic             CdrDelClk,
  input  logic             ResetB,
  input  logic             CdrCmdClk,
  input  logic             SelClkPhase,
  input  logic [SEL_W-1:0] ClkFineDelay,
  input  logic             ClrErr,
  output logic             Clk160,
  output logic [SEL_W-1:0] ActiveTap,
  output logic             PhaseActive,
  output logic             Busy,
  output logic             SwitchErr,
  output logic [15:0]      SwitchCnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_LOW = 2'd1,
    HOLD     = 2'd2,
    SETTLE   = 2'd3
  } state_t;

  localparam logic [TMR_W-1:0] HOLD_LOAD    = TMR_W'(NTAPS + 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT);
  localparam logic [TMR_W-1:0] SETTLE_LOAD  = TMR_W'(SETTLE_CYC - 1);
  localparam logic [SEL_W-1:0] MAX_TAP      = SEL_W'(NTAPS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [NTAPS-1:0] line;
  logic [NTAPS-1:1] line_q;
  logic [SEL_W-1:0] tgt;
  logic [SEL_W-1:0] tap_nxt;
  logic             phase_nxt;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_nxt;
  logic             err_set;
  logic             switch_done;

  // Tap 0 is the phased input itself; deeper taps are successive CdrDelClk samples of it.
  assign line = {line_q, CdrCmdClk ^ PhaseActive};
  assign tgt  = (int'(ClkFineDelay) > NTAPS - 1) ? MAX_TAP : ClkFineDelay;
  assign Busy = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    tap_nxt     = ActiveTap;
    phase_nxt   = PhaseActive;
    timer_nxt   = timer;
    err_set     = 1'b0;
    switch_done = 1'b0;
    case (state)
      IDLE: begin
        if (SelClkPhase != PhaseActive) begin
          state_nxt = HOLD;
          phase_nxt = SelClkPhase;
          tap_nxt   = tgt;
          timer_nxt = HOLD_LOAD;
        end else if (tgt != ActiveTap) begin
          state_nxt = WAIT_LOW;
          timer_nxt = TIMEOUT_LOAD;
        end
      end
      WAIT_LOW: begin
        if (SelClkPhase != PhaseActive) begin
          state_nxt = HOLD;
          phase_nxt = SelClkPhase;
          tap_nxt   = tgt;
          timer_nxt = HOLD_LOAD;
        end else if (tgt == ActiveTap) begin
          state_nxt = IDLE;
        end else if (!line[ActiveTap] && !line[tgt]) begin
          // Both taps low: swapping here cannot create a runt or a double edge.
          tap_nxt   = tgt;
          state_nxt = SETTLE;
          timer_nxt = SETTLE_LOAD;
        end else if (timer == '0) begin
          tap_nxt   = tgt;
          err_set   = 1'b1;
          state_nxt = SETTLE;
          timer_nxt = SETTLE_LOAD;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      HOLD: begin
        tap_nxt = tgt;
        if (timer != '0) begin
          timer_nxt = timer - 1'b1;
        end else if (!line[ActiveTap]) begin
          state_nxt = SETTLE;
          timer_nxt = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (timer == '0) begin
          state_nxt   = IDLE;
          switch_done = 1'b1;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output is forced low during HOLD so the line can refill with the new phase unseen.
  always_ff @(posedge CdrDelClk) begin
    if (!ResetB) begin
      state       <= IDLE;
      line_q      <= '0;
      Clk160      <= 1'b0;
      ActiveTap   <= '0;
      PhaseActive <= 1'b0;
      timer       <= '0;
      SwitchErr   <= 1'b0;
    end else begin
      state       <= state_nxt;
      line_q      <= line[NTAPS-2:0];
      Clk160      <= (state == HOLD) ? 1'b0 : line[ActiveTap];
      ActiveTap   <= tap_nxt;
      PhaseActive <= phase_nxt;
      timer       <= timer_nxt;
      if (err_set) begin
        SwitchErr <= 1'b1;
      end else if (ClrErr) begin
        SwitchErr <= 1'b0;
      end
    end
  end

`ifdef CMD_CLK_SWITCH_CNT_EN
  logic [15:0] switch_cnt;

  always_ff @(posedge CdrDelClk) begin
    if (!ResetB) begin
      switch_cnt <= '0;
    end else if (switch_done && (switch_cnt != 16'hFFFF)) begin
      switch_cnt <= switch_cnt + 16'd1;
    end
  end

  assign SwitchCnt = switch_cnt;
`else
  logic switch_done_unused;

  assign switch_done_unused = switch_done;
  assign SwitchCnt          = 16'h0;
`endif

endmodule

// File: tb/tb_cmd_clk_phase_delay_line.sv
// Directed bench for cmd_clk_phase_delay_line: switch completions are scored from a queue by a monitor.
// NTAPS=12 is used so that an out-of-range ClkFineDelay really exercises the clamp.
module tb_cmd_clk_phase_delay_line;

  localparam int NTAPS      = 12;
  localparam int SEL_W      = 4;
  localparam int TIMEOUT    = 255;
  localparam int SETTLE_CYC = 4;
  localparam int TMR_W      = 8;

  typedef struct {
    int tap;
    bit ph;
    bit err;
  } exp_t;

  logic             clk;
  logic             ResetB;
  logic             CdrCmdClk;
  logic             SelClkPhase;
  logic [SEL_W-1:0] ClkFineDelay;
  logic             ClrErr;
  logic             Clk160;
  logic [SEL_W-1:0] ActiveTap;
  logic             PhaseActive;
  logic             Busy;
  logic             SwitchErr;
  logic [15:0]      SwitchCnt;

  int   checks    = 0;
  int   errors    = 0;
  int   cyc       = 0;
  bit   cmd_run   = 1'b1;
  logic cmd_hold  = 1'b0;
  int   cmd_cnt   = 0;
  bit   runt_en   = 1'b0;
  int   runt_cnt  = 0;
  logic hist [0:16383];
  exp_t exp_q [$];

  cmd_clk_phase_delay_line #(
    .NTAPS(NTAPS), .SEL_W(SEL_W), .TIMEOUT(TIMEOUT), .SETTLE_CYC(SETTLE_CYC), .TMR_W(TMR_W)
  ) dut (
    .CdrDelClk(clk),
    .ResetB(ResetB),
    .CdrCmdClk(CdrCmdClk),
    .SelClkPhase(SelClkPhase),
    .ClkFineDelay(ClkFineDelay),
    .ClrErr(ClrErr),
    .Clk160(Clk160),
    .ActiveTap(ActiveTap),
    .PhaseActive(PhaseActive),
    .Busy(Busy),
    .SwitchErr(SwitchErr),
    .SwitchCnt(SwitchCnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // hist[n] is the command clock value sampled at rising edge n+1.
  initial begin
    CdrCmdClk = 1'b0;
    forever begin
      @(negedge clk);
      if (cmd_run) begin
        cmd_cnt++;
        CdrCmdClk = cmd_cnt[1];
      end else begin
        CdrCmdClk = cmd_hold;
      end
      if (cyc < 16384) hist[cyc] = CdrCmdClk;
    end
  end

  initial begin
    logic prev;
    int   run_len;
    bit   run_valid;
    prev      = 1'b0;
    run_len   = 0;
    run_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (Clk160 !== prev) begin
        if (runt_en && run_valid && run_len < 2) runt_cnt++;
        run_valid = runt_en;
        run_len   = 1;
        prev      = Clk160;
      end else begin
        run_len++;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input int fine, input bit phase, input bit push,
                               input int exp_tap, input bit exp_err);
    exp_t e;
    ClkFineDelay = SEL_W'(fine);
    SelClkPhase  = phase;
    if (push) begin
      e.tap = exp_tap;
      e.ph  = phase;
      e.err = exp_err;
      exp_q.push_back(e);
    end
  endtask

  // Scoreboard monitor: a Busy fall outside reset marks a completed switch.
  initial begin
    bit   busy_prev;
    exp_t e;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!ResetB) begin
        busy_prev = 1'b0;
      end else begin
        if (busy_prev && !Busy) begin
          if (exp_q.size() == 0) begin
            checkOutput("sb_unexpected_switch", 1, 0);
          end else begin
            e = exp_q.pop_front();
            checkOutput("sb_tap", int'(ActiveTap), e.tap);
            checkOutput("sb_phase", int'(PhaseActive), int'(e.ph));
            checkOutput("sb_err", int'(SwitchErr), int'(e.err));
          end
        end
        busy_prev = Busy;
      end
    end
  end

  task automatic waitBusy(input bit level, input int limit, input string name, output int n);
    n = 0;
    while (Busy !== level && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (Busy !== level) checkOutput({name, "_timeout"}, int'(Busy), int'(level));
  endtask

  task automatic waitTap(input int tap, input int limit, input string name, output int n);
    n = 0;
    while (int'(ActiveTap) != tap && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (int'(ActiveTap) != tap) checkOutput({name, "_timeout"}, int'(ActiveTap), tap);
  endtask

  task automatic checkDelay(input int tap, input bit ph, input int n);
    repeat (n) begin
      @(negedge clk);
      checkOutput("clk160_delay", int'(Clk160), int'(hist[cyc - 1 - tap] ^ ph));
    end
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, "_clk160"}, int'(Clk160), 0);
    checkOutput({name, "_tap"}, int'(ActiveTap), 0);
    checkOutput({name, "_phase"}, int'(PhaseActive), 0);
    checkOutput({name, "_busy"}, int'(Busy), 0);
    checkOutput({name, "_err"}, int'(SwitchErr), 0);
    checkOutput({name, "_cnt"}, int'(SwitchCnt), 0);
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int zeros;
    ResetB       = 1'b0;
    ClkFineDelay = '0;
    SelClkPhase  = 1'b0;
    ClrErr       = 1'b0;
    repeat (3) @(negedge clk);
    checkResetState("reset");
    ResetB = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("idle_busy", int'(Busy), 0);
    checkDelay(0, 1'b0, 6);

    $display("[TB] tap 0 -> 5 on a common low");
    applyStimulus(5, 1'b0, 1'b1, 5, 1'b0);
    runt_en = 1'b1;
    waitBusy(1'b1, 5, "t2_rise", n);
    checkOutput("t2_rise_lat", n, 1);
    waitTap(5, 50, "t2_switch", n);
    checkOutput("t2_err", int'(SwitchErr), 0);
    waitBusy(1'b0, 20, "t2_settle", n);
    checkOutput("t2_settle_len", n, SETTLE_CYC);
    checkDelay(5, 1'b0, 8);
    runt_en = 1'b0;
    checkOutput("t2_runt", runt_cnt, 0);

    $display("[TB] phase flip with tap 3");
    applyStimulus(3, 1'b1, 1'b1, 3, 1'b0);
    waitBusy(1'b1, 5, "t3_rise", n);
    zeros = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (Clk160 !== 1'b0) break;
      zeros++;
    end
    checkOutput("t3_hold_low", int'(zeros >= NTAPS + 1), 1);
    waitBusy(1'b0, 100, "t3_done", n);
    checkOutput("t3_phase", int'(PhaseActive), 1);
    checkDelay(3, 1'b1, 8);

    $display("[TB] stuck-high input forces a timeout");
    applyStimulus(3, 1'b0, 1'b1, 3, 1'b0);
    waitBusy(1'b1, 5, "t4_ph_rise", n);
    waitBusy(1'b0, 100, "t4_ph_done", n);
    cmd_run  = 1'b0;
    cmd_hold = 1'b1;
    repeat (NTAPS + 4) @(negedge clk);
    applyStimulus(7, 1'b0, 1'b1, 7, 1'b1);
    waitBusy(1'b1, 5, "t4_rise", n);
    waitTap(7, 400, "t4_switch", n);
    checkOutput("t4_timeout_len", n, TIMEOUT + 1);
    checkOutput("t4_err_set", int'(SwitchErr), 1);
    waitBusy(1'b0, 20, "t4_settle", n);
    checkOutput("t4_err_sticky", int'(SwitchErr), 1);
    ClrErr = 1'b1;
    @(negedge clk);
    ClrErr = 1'b0;
    checkOutput("t4_err_clr", int'(SwitchErr), 0);

    $display("[TB] clamp and request during SETTLE");
    cmd_run = 1'b1;
    repeat (NTAPS + 4) @(negedge clk);
    applyStimulus(15, 1'b0, 1'b1, NTAPS - 1, 1'b0);
    waitBusy(1'b1, 5, "t5_rise", n);
    waitTap(NTAPS - 1, 300, "t5_clamp", n);
    applyStimulus(2, 1'b0, 1'b1, 2, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("t5_settle_ignore", int'(ActiveTap), NTAPS - 1);
    checkOutput("t5_settle_busy", int'(Busy), 1);
    waitBusy(1'b0, 10, "t5_settle", n);
    waitBusy(1'b1, 5, "t5_reservice", n);
    checkOutput("t5_reservice_lat", n, 1);
    waitBusy(1'b0, 300, "t5_done", n);
    checkDelay(2, 1'b0, 6);

    $display("[TB] reset during WAIT_LOW and HOLD");
    cmd_run  = 1'b0;
    cmd_hold = 1'b1;
    repeat (NTAPS + 4) @(negedge clk);
    applyStimulus(9, 1'b0, 1'b0, 0, 1'b0);
    waitBusy(1'b1, 5, "t6_wl_rise", n);
    repeat (5) @(negedge clk);
    checkOutput("t6_wl_pre_clk", int'(Clk160), 1);
    ResetB       = 1'b0;
    ClkFineDelay = '0;
    @(negedge clk);
    checkResetState("t6_waitlow");
    @(negedge clk);
    ResetB  = 1'b1;
    cmd_run = 1'b1;
    repeat (NTAPS + 4) @(negedge clk);
    applyStimulus(0, 1'b1, 1'b0, 0, 1'b0);
    waitBusy(1'b1, 5, "t6_hold_rise", n);
    repeat (3) @(negedge clk);
    checkOutput("t6_hold_pre_phase", int'(PhaseActive), 1);
    ResetB      = 1'b0;
    SelClkPhase = 1'b0;
    @(negedge clk);
    checkResetState("t6_hold");
    @(negedge clk);
    ResetB = 1'b1;

    $display("[TB] three completed switches");
    repeat (4) @(negedge clk);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(i, 1'b0, 1'b1, i, 1'b0);
      waitBusy(1'b1, 5, "cnt_rise", n);
      waitBusy(1'b0, 300, "cnt_done", n);
    end
`ifdef CMD_CLK_SWITCH_CNT_EN
    checkOutput("switch_cnt", int'(SwitchCnt), 3);
`else
    checkOutput("switch_cnt", int'(SwitchCnt), 0);
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    checkOutput("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
